// File: rtl/multicycle_controller.sv
// Main control FSM for the multicycle core: sequences fetch/decode/execute/memory/writeback
// and decodes IR fields into datapath selects; enables are gated off while reset is high.
module multicycle_controller #(
  parameter bit UNKNOWN_HOLD = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] operation_code,
  input  logic [5:0] function_id,
  input  logic [3:0] destination_register,
  input  logic       condition_passed,
  output logic       program_counter_write,
  output logic       address_source,
  output logic       instruction_register_write,
  output logic       memory_write_enable,
  output logic       register_write_enable,
  output logic [1:0] result_source,
  output logic       alu_source_a,
  output logic [1:0] alu_source_b,
  output logic [1:0] immediate_source,
  output logic [1:0] register_source,
  output logic [1:0] alu_control,
  output logic [1:0] flag_write,
  output logic       illegal_instruction
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR,
    EXECUTER, EXECUTEI, ALUWB, BRANCH, UNKNOWN
  } state_t;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  state_t     state;
  logic       is_cmp;
  logic       alu_known;
  logic [1:0] dec_alu;
  logic [1:0] dec_flags;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:  state <= DECODE;
        DECODE: begin
          if (!condition_passed) begin
            state <= FETCH;
          end else begin
            case (operation_code)
              2'b01:   state <= MEMADR;
              2'b00:   state <= function_id[5] ? EXECUTEI : EXECUTER;
              2'b10:   state <= BRANCH;
              default: state <= UNKNOWN;
            endcase
          end
        end
        MEMADR:   state <= function_id[0] ? MEMRD : MEMWR;
        MEMRD:    state <= MEMWB;
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        UNKNOWN:  state <= UNKNOWN_HOLD ? UNKNOWN : FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

  assign is_cmp = (function_id[4:1] == 4'b1010);

  always_comb begin
    dec_alu   = ALU_ADD;
    alu_known = 1'b1;
    case (function_id[4:1])
      4'b0100: dec_alu = ALU_ADD;
      4'b0010: dec_alu = ALU_SUB;
      4'b0000: dec_alu = ALU_AND;
      4'b1100: dec_alu = ALU_ORR;
      4'b1010: dec_alu = ALU_SUB;
      default: alu_known = 1'b0;
    endcase
    // ADD/SUB are the only ops that produce meaningful carry/overflow
    if (is_cmp)          dec_flags = 2'b11;
    else if (!alu_known) dec_flags = 2'b00;
    else                 dec_flags = {function_id[0], function_id[0] & ~dec_alu[1]};
  end

  assign immediate_source = operation_code;
  assign register_source  = {operation_code == 2'b01, operation_code == 2'b10};

  always_comb begin
    program_counter_write      = 1'b0;
    address_source             = 1'b0;
    instruction_register_write = 1'b0;
    memory_write_enable        = 1'b0;
    register_write_enable      = 1'b0;
    result_source              = 2'b00;
    alu_source_a               = 1'b0;
    alu_source_b               = 2'b00;
    alu_control                = ALU_ADD;
    flag_write                 = 2'b00;
    illegal_instruction        = 1'b0;
    case (state)
      FETCH: begin
        alu_source_a               = 1'b1;
        alu_source_b               = 2'b10;
        result_source              = 2'b10;
        instruction_register_write = 1'b1;
        program_counter_write      = 1'b1;
      end
      DECODE: begin
        alu_source_a  = 1'b1;
        alu_source_b  = 2'b10;
        result_source = 2'b10;
      end
      MEMADR: alu_source_b = 2'b01;
      MEMRD:  address_source = 1'b1;
      MEMWB: begin
        result_source         = 2'b01;
        register_write_enable = 1'b1;
      end
      MEMWR: begin
        address_source      = 1'b1;
        memory_write_enable = 1'b1;
      end
      EXECUTER, EXECUTEI: begin
        alu_source_b = (state == EXECUTEI) ? 2'b01 : 2'b00;
        alu_control  = dec_alu;
        flag_write   = dec_flags;
      end
      ALUWB: begin
        register_write_enable = !is_cmp && (destination_register != 4'hF);
        program_counter_write = !is_cmp && (destination_register == 4'hF);
      end
      BRANCH: begin
        alu_source_b          = 2'b01;
        result_source         = 2'b10;
        program_counter_write = 1'b1;
      end
      UNKNOWN: illegal_instruction = 1'b1;
      default: ;
    endcase
    // Reset aborts the instruction in flight without any partial write
    if (reset) begin
      program_counter_write      = 1'b0;
      instruction_register_write = 1'b0;
      memory_write_enable        = 1'b0;
      register_write_enable      = 1'b0;
      flag_write                 = 2'b00;
      illegal_instruction        = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller: directed instruction table, reset
// corner sequences and random instructions checked against an instruction-level model.
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] operation_code;
  logic [5:0] function_id;
  logic [3:0] destination_register;
  logic       condition_passed;
  logic       program_counter_write, address_source, instruction_register_write;
  logic       memory_write_enable, register_write_enable, alu_source_a, illegal_instruction;
  logic [1:0] result_source, alu_source_b, immediate_source, register_source;
  logic [1:0] alu_control, flag_write;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.UNKNOWN_HOLD(1'b0)) dut (
    .clk(clk), .reset(reset),
    .operation_code(operation_code), .function_id(function_id),
    .destination_register(destination_register), .condition_passed(condition_passed),
    .program_counter_write(program_counter_write), .address_source(address_source),
    .instruction_register_write(instruction_register_write),
    .memory_write_enable(memory_write_enable), .register_write_enable(register_write_enable),
    .result_source(result_source), .alu_source_a(alu_source_a), .alu_source_b(alu_source_b),
    .immediate_source(immediate_source), .register_source(register_source),
    .alu_control(alu_control), .flag_write(flag_write),
    .illegal_instruction(illegal_instruction)
  );

  typedef struct packed {
    logic       pcw, asrc, irw, mwe, rwe;
    logic [1:0] rs;
    logic       asa;
    logic [1:0] asb, imm, rgs, aluc, fw;
    logic       ill;
  } out_t;

  typedef struct packed {
    logic [3:0] len, pcw, rwe, mwe, ill;
    logic [1:0] fw;
  } summ_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] fid;
    logic [3:0] rd;
    logic       cond;
    summ_t      exp;
  } vec_t;

  out_t dut_o;
  assign dut_o = {program_counter_write, address_source, instruction_register_write,
                  memory_write_enable, register_write_enable, result_source, alu_source_a,
                  alu_source_b, immediate_source, register_source, alu_control,
                  flag_write, illegal_instruction};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Instruction-level reference: length and per-cycle outputs, cycle 0 being FETCH
  function automatic int model_len(input logic [1:0] op, input logic [5:0] fid, input logic cond);
    if (!cond)             return 2;
    if (op == 2'b01)       return fid[0] ? 5 : 4;
    if (op == 2'b00)       return 4;
    return 3;
  endfunction

  function automatic out_t model(input logic [1:0] op, input logic [5:0] fid,
                                 input logic [3:0] rd, input int k);
    out_t       o;
    logic [1:0] alu;
    logic       known, cmp;
    logic [1:0] flags;
    o     = '0;
    o.imm = op;
    o.rgs = {op == 2'b01, op == 2'b10};
    known = 1'b1;
    alu   = 2'd0;
    case (fid[4:1])
      4'b0100: alu = 2'd0;   // ADD
      4'b0010: alu = 2'd1;   // SUB
      4'b0000: alu = 2'd2;   // AND
      4'b1100: alu = 2'd3;   // ORR
      4'b1010: alu = 2'd1;   // CMP
      default: known = 1'b0;
    endcase
    cmp   = (fid[4:1] == 4'b1010);
    flags = cmp ? 2'b11 : !known ? 2'b00 : {fid[0], fid[0] && (alu < 2)};
    if (k == 0) begin
      o.pcw = 1; o.irw = 1; o.asa = 1; o.asb = 2'b10; o.rs = 2'b10;
    end else if (k == 1) begin
      o.asa = 1; o.asb = 2'b10; o.rs = 2'b10;
    end else if (op == 2'b01) begin
      if (k == 2) o.asb = 2'b01;
      if (k == 3) begin o.asrc = 1; o.mwe = !fid[0]; end
      if (k == 4) begin o.rs = 2'b01; o.rwe = 1; end
    end else if (op == 2'b00) begin
      if (k == 2) begin o.asb = fid[5] ? 2'b01 : 2'b00; o.aluc = alu; o.fw = flags; end
      if (k == 3) begin o.rwe = !cmp && rd != 4'hF; o.pcw = !cmp && rd == 4'hF; end
    end else if (op == 2'b10) begin
      o.asb = 2'b01; o.rs = 2'b10; o.pcw = 1;
    end else begin
      o.ill = 1;
    end
    return o;
  endfunction

  // Called mid-way through a FETCH cycle; returns mid-way through the next FETCH
  task automatic run_instr(input logic [1:0] op, input logic [5:0] fid, input logic [3:0] rd,
                           input logic cond, input string tag, output summ_t s);
    bit done;
    int mlen;
    done = 0;
    s    = '0;
    mlen = model_len(op, fid, cond);
    operation_code = op; function_id = fid; destination_register = rd; condition_passed = cond;
    #1;
    for (int k = 0; k < 12; k++) begin
      if (k > 0) begin
        @(posedge clk);
        @(negedge clk);
        if (instruction_register_write) begin done = 1; break; end
      end
      if (k < mlen) check($sformatf("%s cyc%0d", tag, k), 32'(dut_o), 32'(model(op, fid, rd, k)));
      s.len = s.len + 1;
      s.pcw = s.pcw + 4'(program_counter_write);
      s.rwe = s.rwe + 4'(register_write_enable);
      s.mwe = s.mwe + 4'(memory_write_enable);
      s.ill = s.ill + 4'(illegal_instruction);
      s.fw  = s.fw | flag_write;
    end
    if (!done) check({tag, " next_fetch_timeout"}, 32'd0, 32'd1);
    check({tag, " length"}, 32'(s.len), 32'(mlen));
  endtask

  function automatic logic enables_any();
    return program_counter_write | instruction_register_write | memory_write_enable |
           register_write_enable | (|flag_write) | illegal_instruction;
  endfunction

  // Walks an instruction `steps` edges in, checks one output there, then resets mid-cycle
  task automatic reset_mid(input logic [1:0] op, input logic [5:0] fid, input logic [3:0] rd,
                           input int steps, input string tag, input logic [1:0] which);
    logic pre;
    operation_code = op; function_id = fid; destination_register = rd; condition_passed = 1;
    #1;
    repeat (steps) @(posedge clk);
    @(negedge clk);
    pre = (which == 2'd0) ? memory_write_enable : register_write_enable;
    check({tag, " before_reset"}, 32'(pre), 32'd1);
    reset = 1'b1;
    #1;
    check({tag, " enables_in_reset"}, 32'(enables_any()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check({tag, " fetch_after_reset"}, 32'({instruction_register_write, program_counter_write}), 32'b11);
  endtask

  vec_t  vecs[$];
  summ_t got;

  initial begin
    //         op     fid        rd    c   {len, pcw, rwe, mwe, ill, fw}
    vecs.push_back('{2'b00, 6'b001000, 4'h1, 1'b1, '{4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00}}); // ADD
    vecs.push_back('{2'b01, 6'b011001, 4'h2, 1'b1, '{4'd5, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00}}); // LDR
    vecs.push_back('{2'b01, 6'b011000, 4'h2, 1'b1, '{4'd4, 4'd1, 4'd0, 4'd1, 4'd0, 2'b00}}); // STR
    vecs.push_back('{2'b10, 6'b000000, 4'h0, 1'b1, '{4'd3, 4'd2, 4'd0, 4'd0, 4'd0, 2'b00}}); // B
    vecs.push_back('{2'b00, 6'b000101, 4'hF, 1'b1, '{4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 2'b11}}); // SUBS R15
    vecs.push_back('{2'b00, 6'b001001, 4'h3, 1'b0, '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00}}); // skipped ADDS
    vecs.push_back('{2'b01, 6'b011000, 4'h3, 1'b0, '{4'd2, 4'd1, 4'd0, 4'd0, 4'd0, 2'b00}}); // skipped STR
    vecs.push_back('{2'b11, 6'b000000, 4'h0, 1'b1, '{4'd3, 4'd1, 4'd0, 4'd0, 4'd1, 2'b00}}); // illegal
    vecs.push_back('{2'b00, 6'b010101, 4'hF, 1'b1, '{4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 2'b11}}); // CMP Rd=15
    vecs.push_back('{2'b00, 6'b010100, 4'h4, 1'b1, '{4'd4, 4'd1, 4'd0, 4'd0, 4'd0, 2'b11}}); // CMP no S
    vecs.push_back('{2'b00, 6'b100001, 4'h3, 1'b1, '{4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 2'b10}}); // ANDS imm
    vecs.push_back('{2'b00, 6'b011000, 4'hF, 1'b1, '{4'd4, 4'd2, 4'd0, 4'd0, 4'd0, 2'b00}}); // ORR R15
    vecs.push_back('{2'b00, 6'b000111, 4'h5, 1'b1, '{4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 2'b00}}); // undefined ALU op, S
    vecs.push_back('{2'b00, 6'b101001, 4'h6, 1'b1, '{4'd4, 4'd1, 4'd1, 4'd0, 4'd0, 2'b11}}); // ADDS imm

    reset = 1'b1;
    operation_code = 2'b01; function_id = 6'b011000; destination_register = 4'h0;
    condition_passed = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("enables_during_reset", 32'(enables_any()), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("first_cycle_is_fetch", 32'({instruction_register_write, program_counter_write}), 32'b11);

    foreach (vecs[i]) begin
      run_instr(vecs[i].op, vecs[i].fid, vecs[i].rd, vecs[i].cond, $sformatf("vec%0d", i), got);
      check($sformatf("vec%0d summary", i), 32'(got), 32'(vecs[i].exp));
    end

    reset_mid(2'b01, 6'b011000, 4'h1, 3, "reset_in_memwr", 2'd0);
    reset_mid(2'b01, 6'b011001, 4'h1, 4, "reset_in_memwb", 2'd1);
    reset_mid(2'b00, 6'b001000, 4'h2, 3, "reset_in_aluwb", 2'd1);

    for (int n = 0; n < 250; n++) begin
      logic [1:0] op;
      logic [5:0] fid;
      logic [3:0] rd;
      logic       cond;
      op   = 2'($urandom_range(0, 3));
      fid  = 6'($urandom_range(0, 63));
      rd   = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      cond = ($urandom_range(0, 9) != 0);
      run_instr(op, fid, rd, cond, $sformatf("rnd%0d op%0b fid%06b rd%0h c%0b", n, op, fid, rd, cond), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
